// File: rtl/bcd_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_addsub_ctrl
//
// Purpose:
//    Sequences one shared single-digit BCD adder to perform DIGITS-wide BCD
//    addition or subtraction, one digit per clock, least significant digit
//    first. Subtraction is A + 9's-complement(B) + 1. A negative difference
//    is re-complemented by a second pass (CORR) through the same adder, so
//    the result comes back as sign + magnitude.
//
// Ports:
//    clk      in   system clock, rising edge
//    rst_n    in   synchronous, active-low reset
//    start    in   operation request, sampled only in IDLE
//    sub      in   0 = A+B, 1 = A-B (latched with start)
//    a, b     in   packed BCD operands, digit 0 at [3:0]
//    da_o     out  digit adder operand 1
//    db_o     out  digit adder operand 2
//    dcin_o   out  digit adder carry in
//    dsum_i   in   digit adder BCD sum (combinational, same cycle)
//    dcout_i  in   digit adder decimal carry out
//    busy     out  high whenever not IDLE
//    done     out  one-cycle completion pulse
//    result   out  BCD magnitude
//    cout     out  add: decimal overflow; sub: always 0
//    neg      out  sub: result negative; add: always 0
// ---------------------------------------------------------------------------
module bcd_serial_addsub_ctrl #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sub,
   input  logic [4*DIGITS-1:0] a,
   input  logic [4*DIGITS-1:0] b,
   output logic [3:0]          da_o,
   output logic [3:0]          db_o,
   output logic                dcin_o,
   input  logic [3:0]          dsum_i,
   input  logic                dcout_i,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] result,
   output logic                cout,
   output logic                neg
);

   localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int N_SLOTS = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADD  = 2'd1;
   localparam logic [1:0] S_CORR = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]          r_state;
   logic [4*DIGITS-1:0] r_a;
   logic [4*DIGITS-1:0] r_b;
   logic                r_sub;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [4*DIGITS-1:0] r_result;
   logic                r_cout;
   logic                r_neg;

   // Digit views padded to a power of two so any idx value selects a
   // defined slot; the unused slots are never reached.
   logic [3:0] w_a_dig [N_SLOTS];
   logic [3:0] w_b_dig [N_SLOTS];
   logic [3:0] w_r_dig [N_SLOTS];
   logic [3:0] w_a_cur;
   logic [3:0] w_b_cur;
   logic [3:0] w_r_cur;
   logic       w_last;

   genvar gi;
   generate
      for (gi = 0; gi < N_SLOTS; gi++) begin : g_dig
         if (gi < DIGITS) begin : g_real
            assign w_a_dig[gi] = r_a[4*gi +: 4];
            assign w_b_dig[gi] = r_b[4*gi +: 4];
            assign w_r_dig[gi] = r_result[4*gi +: 4];
         end else begin : g_pad
            assign w_a_dig[gi] = 4'd0;
            assign w_b_dig[gi] = 4'd0;
            assign w_r_dig[gi] = 4'd0;
         end
      end
   endgenerate

   assign w_a_cur = w_a_dig[r_idx];
   assign w_b_cur = w_b_dig[r_idx];
   assign w_r_cur = w_r_dig[r_idx];
   assign w_last  = (r_idx == LAST_IDX);

   // Adder operands are driven from state so the adder sum is available
   // within the same cycle for capture at the next edge.
   always_comb begin
      da_o   = 4'd0;
      db_o   = 4'd0;
      dcin_o = 1'b0;
      case (r_state)
         S_ADD: begin
            da_o   = w_a_cur;
            db_o   = r_sub ? (4'd9 - w_b_cur) : w_b_cur;
            dcin_o = r_carry;
         end
         S_CORR: begin
            db_o   = 4'd9 - w_r_cur;
            dcin_o = r_carry;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_neg    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a      <= a;
                  r_b      <= b;
                  r_sub    <= sub;
                  r_result <= '0;
                  r_cout   <= 1'b0;
                  r_neg    <= 1'b0;
                  r_idx    <= '0;
                  // Subtraction's "+1" enters as the initial carry.
                  r_carry  <= sub;
                  r_state  <= S_ADD;
               end
            end
            S_ADD, S_CORR: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (r_idx == IDX_W'(i)) begin
                     r_result[4*i +: 4] <= dsum_i;
                  end
               end
               r_carry <= dcout_i;
               if (!w_last) begin
                  r_idx <= r_idx + 1'b1;
               end else if (r_state == S_CORR) begin
                  // End carry of the re-complement pass is meaningless.
                  r_state <= S_DONE;
               end else if (!r_sub) begin
                  r_cout  <= dcout_i;
                  r_state <= S_DONE;
               end else if (dcout_i) begin
                  r_state <= S_DONE;
               end else begin
                  // No end carry on subtract: A<B, result is the 10's
                  // complement of the magnitude, so complement it again.
                  r_neg   <= 1'b1;
                  r_idx   <= '0;
                  r_carry <= 1'b1;
                  r_state <= S_CORR;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign cout   = r_cout;
   assign neg    = r_neg;

endmodule

// File: tb/tb_bcd_serial_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_addsub_ctrl
//
// Purpose:
//    Self-checking bench for bcd_serial_addsub_ctrl (DIGITS=4). Provides a
//    behavioural single-digit BCD adder and an integer reference model of
//    the signed-magnitude add/subtract result and of the latency.
// ---------------------------------------------------------------------------
module tb_bcd_serial_addsub_ctrl;

   localparam int D = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          sub;
   logic [4*D-1:0] a;
   logic [4*D-1:0] b;
   logic [3:0]    da_o;
   logic [3:0]    db_o;
   logic          dcin_o;
   logic [3:0]    dsum_i;
   logic          dcout_i;
   logic          busy;
   logic          done;
   logic [4*D-1:0] result;
   logic          cout;
   logic          neg;

   int checks;
   int failures;

   bcd_serial_addsub_ctrl #(.DIGITS(D)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .sub     (sub),
      .a       (a),
      .b       (b),
      .da_o    (da_o),
      .db_o    (db_o),
      .dcin_o  (dcin_o),
      .dsum_i  (dsum_i),
      .dcout_i (dcout_i),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .cout    (cout),
      .neg     (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-digit decimal adder.
   logic [4:0] w_tot;
   assign w_tot   = {1'b0, da_o} + {1'b0, db_o} + {4'd0, dcin_o};
   assign dcout_i = (w_tot > 5'd9);
   assign dsum_i  = (w_tot > 5'd9) ? 4'(w_tot - 5'd10) : w_tot[3:0];

   function automatic int bcd2int(input logic [4*D-1:0] v);
      int r;
      r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [4*D-1:0] int2bcd(input int v);
      logic [4*D-1:0] r;
      int t;
      t = v;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference: plain integer arithmetic, signed magnitude, latency rule.
   task automatic model(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                        input logic sv, output logic [4*D-1:0] er,
                        output logic ec, output logic en, output int el);
      int ai, bi, s;
      ai = bcd2int(av);
      bi = bcd2int(bv);
      if (!sv) begin
         s  = ai + bi;
         ec = (s >= 10 ** D);
         er = int2bcd(s % (10 ** D));
         en = 1'b0;
         el = D + 1;
      end else begin
         ec = 1'b0;
         en = (ai < bi);
         er = int2bcd(en ? (bi - ai) : (ai - bi));
         el = en ? (2 * D + 1) : (D + 1);
      end
   endtask

   function automatic logic [4*D-1:0] rand_bcd();
      logic [4*D-1:0] r;
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // Issues one operation and waits (bounded) for done; reports what it saw.
   task automatic do_op(input logic [4*D-1:0] av, input logic [4*D-1:0] bv,
                        input logic sv, output logic [4*D-1:0] res,
                        output logic co, output logic ng,
                        output int lat, output int bc);
      @(negedge clk);
      a = av; b = bv; sub = sv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1; bc = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      if (busy) bc++;
      res = result; co = cout; ng = neg;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; sub = 1'b1; a = 16'h1234; b = 16'h5678;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, cout, neg} !== 4'b0000 || result !== '0 ||
          da_o !== 4'd0 || db_o !== 4'd0 || dcin_o !== 1'b0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b cout=%b neg=%b result=%h da=%h db=%h cin=%b required all zero",
                  busy, done, cout, neg, result, da_o, db_o, dcin_o);
      end
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_directed();
      logic [4*D-1:0] ta [6];
      logic [4*D-1:0] tb [6];
      logic           ts [6];
      logic [4*D-1:0] res, er;
      logic co, ng, ec, en;
      int lat, bc, el;
      ta = '{16'h1234, 16'h9999, 16'h5000, 16'h4321, 16'h1234, 16'h0000};
      tb = '{16'h5678, 16'h0001, 16'h1234, 16'h4321, 16'h5000, 16'h0001};
      ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         do_op(ta[i], tb[i], ts[i], res, co, ng, lat, bc);
         model(ta[i], tb[i], ts[i], er, ec, en, el);
         $display("directed %0d: %h %s %h -> result=%h cout=%b neg=%b lat=%0d busy_cycles=%0d",
                  i, ta[i], ts[i] ? "-" : "+", tb[i], res, co, ng, lat, bc);
         checks++;
         if (res !== er || co !== ec || ng !== en) begin
            failures++;
            $display("FAIL directed_%0d: result=%h cout=%b neg=%b required result=%h cout=%b neg=%b",
                     i, res, co, ng, er, ec, en);
         end
         checks++;
         if (lat !== el || bc !== el) begin
            failures++;
            $display("FAIL directed_%0d_latency: lat=%0d busy_cycles=%0d required %0d",
                     i, lat, bc, el);
         end
      end
   endtask

   task automatic test_adder_ports();
      int n;
      // 1234-5000: digit 0 is 4 + (9-0) + 1; ADD pass leaves 6234.
      @(negedge clk);
      a = 16'h1234; b = 16'h5000; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (da_o !== 4'd4 || db_o !== 4'd9 || dcin_o !== 1'b1) begin
         failures++;
         $display("FAIL ports_add: da=%h db=%h cin=%b required da=4 db=9 cin=1", da_o, db_o, dcin_o);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (da_o !== 4'd0 || db_o !== 4'd5 || dcin_o !== 1'b1 || neg !== 1'b1) begin
         failures++;
         $display("FAIL ports_corr: da=%h db=%h cin=%b neg=%b required da=0 db=5 cin=1 neg=1",
                  da_o, db_o, dcin_o, neg);
      end
      n = 5;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      $display("ports: 1234-5000 result=%h neg=%b done_cycle=%0d", result, neg, n);
      checks++;
      if (n !== 9 || result !== 16'h3766) begin
         failures++;
         $display("FAIL ports_final: done_cycle=%0d result=%h required 9 and 3766", n, result);
      end
   endtask

   task automatic test_random();
      logic [4*D-1:0] av, bv, res, er;
      logic sv, co, ng, ec, en;
      int lat, bc, el;
      for (int i = 0; i < 40; i++) begin
         av = rand_bcd();
         bv = rand_bcd();
         sv = 1'($urandom_range(0, 1));
         do_op(av, bv, sv, res, co, ng, lat, bc);
         model(av, bv, sv, er, ec, en, el);
         $display("random %0d: %h %s %h -> result=%h cout=%b neg=%b lat=%0d",
                  i, av, sv ? "-" : "+", bv, res, co, ng, lat);
         checks++;
         if (res !== er || co !== ec || ng !== en || lat !== el) begin
            failures++;
            $display("FAIL random_%0d: result=%h cout=%b neg=%b lat=%0d required result=%h cout=%b neg=%b lat=%0d",
                     i, res, co, ng, lat, er, ec, en, el);
         end
      end
   endtask

   task automatic test_ignored_start();
      logic [4*D-1:0] res;
      logic co, ng;
      int lat, bc, n;
      @(negedge clk);
      a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h9999; b = 16'h9998; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 3;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 5 || result !== 16'h6912 || cout !== 1'b0 || neg !== 1'b0) begin
         failures++;
         $display("FAIL ignore_busy: done_cycle=%0d result=%h cout=%b neg=%b required 5 6912 0 0",
                  n, result, cout, neg);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      $display("ignore: start in DONE -> busy=%b done=%b result=%h", busy, done, result);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h6912) begin
         failures++;
         $display("FAIL ignore_done: busy=%b done=%b result=%h required 0 0 6912", busy, done, result);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || result !== 16'h6912) begin
         failures++;
         $display("FAIL ignore_hold: busy=%b result=%h required 0 6912", busy, result);
      end
      do_op(16'h0005, 16'h0005, 1'b0, res, co, ng, lat, bc);
      checks++;
      if (res !== 16'h0010 || lat !== 5) begin
         failures++;
         $display("FAIL ignore_accept: result=%h lat=%0d required 0010 5", res, lat);
      end
   endtask

   task automatic test_mid_reset();
      logic [4*D-1:0] res;
      logic co, ng;
      int lat, bc;
      @(negedge clk);
      a = 16'h9999; b = 16'h0001; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("mid_reset: busy=%b done=%b result=%h cout=%b neg=%b", busy, done, result, cout, neg);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || neg !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: busy=%b done=%b result=%h cout=%b neg=%b required all zero",
                  busy, done, result, cout, neg);
      end
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_quiet: done=%b busy=%b required 0 0", done, busy);
         end
      end
      do_op(16'h0005, 16'h0005, 1'b0, res, co, ng, lat, bc);
      checks++;
      if (res !== 16'h0010 || co !== 1'b0 || ng !== 1'b0 || lat !== 5) begin
         failures++;
         $display("FAIL mid_reset_after: result=%h cout=%b neg=%b lat=%0d required 0010 0 0 5",
                  res, co, ng, lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [4*D-1:0] res, er;
      logic co, ng, ec, en;
      int lat, bc, el;
      do_op(16'h0100, 16'h0200, 1'b1, res, co, ng, lat, bc);
      model(16'h0100, 16'h0200, 1'b1, er, ec, en, el);
      checks++;
      if (res !== er || ng !== en || lat !== el) begin
         failures++;
         $display("FAIL b2b_first: result=%h neg=%b lat=%0d required %h %b %0d", res, ng, lat, er, en, el);
      end
      // Start raised in the very IDLE cycle after DONE must be accepted.
      do_op(16'h0999, 16'h0001, 1'b0, res, co, ng, lat, bc);
      model(16'h0999, 16'h0001, 1'b0, er, ec, en, el);
      $display("b2b: 0999+0001 -> result=%h cout=%b neg=%b lat=%0d", res, co, ng, lat);
      checks++;
      if (res !== er || co !== ec || ng !== en || lat !== el) begin
         failures++;
         $display("FAIL b2b_second: result=%h cout=%b neg=%b lat=%0d required %h %b %b %0d",
                  res, co, ng, lat, er, ec, en, el);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      start = 1'b0;
      sub = 1'b0;
      a = '0;
      b = '0;
      test_reset();
      test_directed();
      test_adder_ports();
      test_random();
      test_ignored_start();
      test_mid_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_serial_addsub_ctrl.md
Name: bcd_serial_addsub_ctrl

Overview:
- Sequencer for one shared single-digit BCD adder. Performs DIGITS-wide BCD addition or subtraction one digit per clock, least significant digit first.
- Subtraction is A + 9's-complement(B) + 1. A negative result is re-complemented by a second pass through the same adder, so the result is returned as sign + magnitude.
- Sits between the arithmetic-unit front end (operand registers, start/sub request) and the digit adder instance.

Parameters:
- DIGITS, 4, number of BCD digits per operand (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A-B; latched with start
- a  in  4*DIGITS  operand A, packed BCD, digit 0 at [3:0]
- b  in  4*DIGITS  operand B, packed BCD
- da_o  out  4  digit adder operand 1
- db_o  out  4  digit adder operand 2
- dcin_o  out  1  digit adder carry in
- dsum_i  in  4  digit adder BCD sum (combinational, same cycle)
- dcout_i  in  1  digit adder decimal carry out
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- result  out  4*DIGITS  BCD magnitude
- cout  out  1  add: decimal overflow; sub: always 0
- neg  out  1  sub: result negative (A<B); add: always 0

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; result=0; cout=0; neg=0; done=0; busy=0; da_o/db_o/dcin_o=0. Reset mid-operation aborts immediately at the next edge with the same values; no partial result is retained.
- States: IDLE, ADD, CORR, DONE.
- IDLE:
  - Adder port outputs are 0.
  - On start=1, latch a, b and sub; clear result, cout and neg; idx=0; carry=sub; go to ADD.
- ADD (one cycle per digit idx):
  - da_o = A[idx].
  - db_o = sub ? (9 - B[idx]) : B[idx].
  - dcin_o = carry.
  - At the edge: result[idx] <= dsum_i; carry <= dcout_i; idx++.
  - Exit after idx = DIGITS-1:
    - add: cout <= dcout_i; go to DONE.
    - sub with dcout_i=1: positive, go to DONE.
    - sub with dcout_i=0: neg <= 1; idx=0; carry=1; go to CORR.
- CORR (one cycle per digit):
  - da_o = 0; db_o = 9 - result[idx]; dcin_o = carry.
  - At the edge: result[idx] <= dsum_i; carry <= dcout_i.
  - After digit DIGITS-1 go to DONE. The final carry is discarded.
- DONE: done=1 for exactly this cycle; next state IDLE. A start in this cycle is ignored.
- Latency, counted from the start-sampling edge to the cycle in which done is high:
  - add, or sub with non-negative result: DIGITS+1 cycles.
  - negative sub: 2*DIGITS+1 cycles.
- busy is a Moore output of state only. A start while busy is ignored and is not queued.
- result, cout and neg hold their values from DONE until the next accepted start.
- Zero result from subtraction (A=B): end carry is 1, so neg=0 and result=0.
- Operand digits >9 are outside the contract: result is undefined, but the FSM must still complete with the stated latency.
- idx width is clog2(DIGITS), minimum 1. idx never wraps past DIGITS-1.

Test Plan (DIGITS=4, digit adder model attached):
- add 1234+5678 -> result=6912, cout=0, neg=0; done in the 5th cycle after the start edge; busy high 5 cycles.
- add 9999+0001 -> result=0000, cout=1, neg=0; every digit propagates carry.
- sub 5000-1234 -> result=3766, neg=0, cout=0, latency 5; also sub 4321-4321 -> result=0000, neg=0.
- sub 1234-5000 -> ADD pass yields 6234 with no end carry; CORR pass yields 3766, neg=1; done at cycle 9.
- start pulsed during ADD and again during DONE -> both ignored, first result unchanged; start in the next IDLE cycle is accepted.
- rst_n=0 in the 2nd ADD cycle -> next cycle IDLE, busy=0, result=0, no done pulse; a new add 0005+0005 afterwards -> 0010.
